// File: rtl/key_state_tracker_pkg.sv
// Shared key/scan-code definitions for the key tracker and the game FSM.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
package key_state_tracker_pkg;

  // Bit positions in held/press/released; the directions come first so that
  // step[3:0] lines up with held[3:0].
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_Z     = 4;
  localparam int K_X     = 5;
  localparam int K_ENTER = 6;
  localparam int K_ESC   = 7;

  localparam int NUM_KEYS = 8;
  localparam int NUM_DIRS = 4;

  // PS/2 set-2 scan codes (low byte; arrows arrive with an E0 prefix that is ignored)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } key_dec_t;

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rp_state_t;

  // Map a scan code to its key index; vld=0 for keys the game does not use.
  function automatic key_dec_t decode_key(input logic [7:0] sc);
    key_dec_t r;
    r.vld = 1'b1;
    r.idx = 3'd0;
    case (sc)
      SC_UP:    r.idx = 3'(K_UP);
      SC_DOWN:  r.idx = 3'(K_DOWN);
      SC_LEFT:  r.idx = 3'(K_LEFT);
      SC_RIGHT: r.idx = 3'(K_RIGHT);
      SC_Z:     r.idx = 3'(K_Z);
      SC_X:     r.idx = 3'(K_X);
      SC_ENTER: r.idx = 3'(K_ENTER);
      SC_ESC:   r.idx = 3'(K_ESC);
      default:  r.vld = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_state_tracker_if.sv
// Bundle between the keyboard stage / game FSM and the key tracker.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// Signals: keycode[15:0] scan-code register, clear_all scene-change drop,
//          held/press/released[7:0] per-key level and pulses, step[3:0] direction steps.
//          ("release" is a language keyword, hence "released".)
interface key_state_tracker_if;
  import key_state_tracker_pkg::*;

  logic [15:0]         keycode;
  logic                clear_all;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] released;
  logic [NUM_DIRS-1:0] step;

  // master: keyboard stage + game FSM side
  modport master (
    output keycode, clear_all,
    input  held, press, released, step
  );

  // slave: the tracker itself
  modport slave (
    input  keycode, clear_all,
    output held, press, released, step
  );
endinterface

// File: rtl/key_state_tracker_repeat.sv
// Auto-repeat step generator for one direction key.
// Latency: step_o is combinational from registered state; first step in the press cycle.
// Backpressure: none; steps are fire-and-forget pulses, the consumer must take them.
// Ports: clk, rst_n, held_i (key level), press_i (press pulse) -> step_o (step pulse).
module key_repeat
  import key_state_tracker_pkg::*;
#(
  parameter int DELAY_CYC = 4,
  parameter int RATE_CYC  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held_i,
  input  logic press_i,
  output logic step_o
);

  localparam int MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(RATE_CYC - 1);

  rp_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RP_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_o    = 1'b0;
    // Dropping the key wins over a counter hit in the same cycle.
    if (!held_i) begin
      state_nxt = RP_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RP_IDLE: begin
          if (press_i) begin
            step_o    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RP_DELAY;
          end
        end
        RP_DELAY: begin
          if (cnt == DLY_LAST) begin
            step_o    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RP_REPEAT;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RP_REPEAT: begin
          if (cnt == RATE_LAST) begin
            step_o  = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = RP_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_state_tracker.sv
// Turns PS/2 make/break scan codes into held levels, press/release pulses and direction steps.
// Latency: keycode change before edge E1 -> held/press/released updated at E1, pulses high E1..E2.
// Backpressure: none; input is a level register sampled every cycle, outputs are pulses/levels.
// Ports: clk, rst_n (async active-low), kbd (slave modport: keycode, clear_all in;
//        held, press, released, step out).
module key_state_tracker
  import key_state_tracker_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int REPEAT_DELAY_MS = 400,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  key_state_tracker_if.slave  kbd
);

  localparam int DELAY_CYC = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RATE_CYC  = CLK_HZ / 1000 * REPEAT_RATE_MS;

  logic [15:0]         kc_d;
  logic                armed;
  logic                evt;
  logic [7:0]          sc_lo;
  logic [7:0]          sc_hi;
  key_dec_t            dec;
  logic [NUM_KEYS-1:0] held_q, held_nxt;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] rel_q;
  logic [NUM_DIRS-1:0] step_w;

  assign sc_lo = kbd.keycode[7:0];
  assign sc_hi = kbd.keycode[15:8];
  assign dec   = decode_key(sc_lo);

  // Reset clears kc_d, so whatever code is still parked on the bus would look
  // new on the first cycle. The first cycle out of reset only resamples, which
  // keeps a key that was down across reset silent until its next make code.
  assign evt = armed && (kbd.keycode != kc_d);

  always_comb begin
    held_nxt = held_q;
    if (kbd.clear_all) begin
      held_nxt = '0;
    end else if (evt && (sc_lo != SC_BREAK) && dec.vld) begin
      // F0 in the high byte is a break, anything else (incl. E0) is a make
      held_nxt[dec.idx] = (sc_hi != SC_BREAK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_d    <= 16'h0000;
      armed   <= 1'b0;
      held_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      kc_d    <= kbd.keycode;
      armed   <= 1'b1;
      held_q  <= held_nxt;
      press_q <= held_nxt & ~held_q;
      rel_q   <= held_q & ~held_nxt;
    end
  end

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_rep
    key_repeat #(
      .DELAY_CYC (DELAY_CYC),
      .RATE_CYC  (RATE_CYC)
    ) u_rep (
      .clk     (clk),
      .rst_n   (rst_n),
      .held_i  (held_q[d]),
      .press_i (press_q[d]),
      .step_o  (step_w[d])
    );
  end

  assign kbd.held     = held_q;
  assign kbd.press    = press_q;
  assign kbd.released = rel_q;
  assign kbd.step     = step_w;

endmodule

// File: tb/tb_key_state_tracker.sv
module tb_key_state_tracker;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  key_state_tracker_if kif();

  key_state_tracker #(
    .CLK_HZ          (1000),
    .REPEAT_DELAY_MS (4),
    .REPEAT_RATE_MS  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kbd   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    kif.keycode = 16'h0075;
    kif.clear_all = 1'b0;
    tick();
    tick();
    n_cmp++; if (kif.held !== 8'h00) begin n_err++; $display("FAIL rst_held: got %h want 00", kif.held); end
    n_cmp++; if (kif.press !== 8'h00) begin n_err++; $display("FAIL rst_press: got %h want 00", kif.press); end
    n_cmp++; if (kif.released !== 8'h00) begin n_err++; $display("FAIL rst_rel: got %h want 00", kif.released); end
    n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL rst_step: got %h want 0", kif.step); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (kif.held !== 8'h00) begin n_err++; $display("FAIL rst_after_held[%0d]: got %h want 00", i, kif.held); end
      n_cmp++; if (kif.press !== 8'h00) begin n_err++; $display("FAIL rst_after_press[%0d]: got %h want 00", i, kif.press); end
    end
  endtask

  task automatic test_make_break();
    kif.keycode = 16'h0000;
    tick();
    kif.keycode = 16'h001A;
    tick();
    n_cmp++; if (kif.held !== 8'h10) begin n_err++; $display("FAIL mk_held: got %h want 10", kif.held); end
    n_cmp++; if (kif.press !== 8'h10) begin n_err++; $display("FAIL mk_press: got %h want 10", kif.press); end
    n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL mk_step: got %h want 0", kif.step); end
    tick();
    n_cmp++; if (kif.press !== 8'h00) begin n_err++; $display("FAIL mk_press_once: got %h want 00", kif.press); end
    n_cmp++; if (kif.held !== 8'h10) begin n_err++; $display("FAIL mk_held_stay: got %h want 10", kif.held); end
    kif.keycode = 16'hF01A;
    tick();
    n_cmp++; if (kif.held !== 8'h00) begin n_err++; $display("FAIL brk_held: got %h want 00", kif.held); end
    n_cmp++; if (kif.released !== 8'h10) begin n_err++; $display("FAIL brk_rel: got %h want 10", kif.released); end
    n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL brk_step: got %h want 0", kif.step); end
    tick();
    n_cmp++; if (kif.released !== 8'h00) begin n_err++; $display("FAIL brk_rel_once: got %h want 00", kif.released); end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] exp_step;
    kif.keycode = 16'hE075;
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp_step = (c == 1 || c == 5 || c == 7 || c == 9 || c == 11) ? 4'b0001 : 4'b0000;
      n_cmp++; if (kif.step !== exp_step) begin n_err++; $display("FAIL rep_step[c%0d]: got %h want %h", c, kif.step, exp_step); end
      if (c == 1) begin
        n_cmp++; if (kif.press !== 8'h01) begin n_err++; $display("FAIL rep_press: got %h want 01", kif.press); end
      end
    end
    kif.keycode = 16'hE0F0;
    tick();
    n_cmp++; if (kif.held !== 8'h01) begin n_err++; $display("FAIL rep_partial_held: got %h want 01", kif.held); end
    n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL rep_partial_step: got %h want 0", kif.step); end
    kif.keycode = 16'hF075;
    tick();
    n_cmp++; if (kif.held !== 8'h00) begin n_err++; $display("FAIL rep_brk_held: got %h want 00", kif.held); end
    n_cmp++; if (kif.released !== 8'h01) begin n_err++; $display("FAIL rep_brk_rel: got %h want 01", kif.released); end
    n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL rep_brk_step: got %h want 0", kif.step); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL rep_after_step[%0d]: got %h want 0", i, kif.step); end
    end
  endtask

  task automatic test_ignored();
    kif.keycode = 16'h001A;
    tick();
    n_cmp++; if (kif.press !== 8'h10) begin n_err++; $display("FAIL ign_zpress: got %h want 10", kif.press); end
    kif.keycode = 16'hF022;
    tick();
    n_cmp++; if (kif.held !== 8'h10) begin n_err++; $display("FAIL ign_xbrk_held: got %h want 10", kif.held); end
    n_cmp++; if (kif.released !== 8'h00) begin n_err++; $display("FAIL ign_xbrk_rel: got %h want 00", kif.released); end
    kif.keycode = 16'h0033;
    tick();
    n_cmp++; if (kif.held !== 8'h10) begin n_err++; $display("FAIL ign_unmap_held: got %h want 10", kif.held); end
    n_cmp++; if (kif.press !== 8'h00) begin n_err++; $display("FAIL ign_unmap_press: got %h want 00", kif.press); end
    kif.keycode = 16'h00F0;
    tick();
    n_cmp++; if (kif.held !== 8'h10) begin n_err++; $display("FAIL ign_f0_held: got %h want 10", kif.held); end
    n_cmp++; if (kif.released !== 8'h00) begin n_err++; $display("FAIL ign_f0_rel: got %h want 00", kif.released); end
    kif.keycode = 16'h001A;
    tick();
    n_cmp++; if (kif.press !== 8'h00) begin n_err++; $display("FAIL ign_remake_press: got %h want 00", kif.press); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL ign_z_norepeat[%0d]: got %h want 0", i, kif.step); end
    end
    kif.keycode = 16'hF01A;
    tick();
    n_cmp++; if (kif.released !== 8'h10) begin n_err++; $display("FAIL ign_zbrk_rel: got %h want 10", kif.released); end
  endtask

  task automatic test_clear_all();
    kif.keycode = 16'h0075;
    tick();
    kif.keycode = 16'h006B;
    tick();
    n_cmp++; if (kif.held !== 8'h05) begin n_err++; $display("FAIL clr_pre_held: got %h want 05", kif.held); end
    kif.keycode = 16'h005A;
    kif.clear_all = 1'b1;
    tick();
    kif.clear_all = 1'b0;
    n_cmp++; if (kif.held !== 8'h00) begin n_err++; $display("FAIL clr_held: got %h want 00", kif.held); end
    n_cmp++; if (kif.released !== 8'h05) begin n_err++; $display("FAIL clr_rel: got %h want 05", kif.released); end
    n_cmp++; if (kif.press !== 8'h00) begin n_err++; $display("FAIL clr_press: got %h want 00", kif.press); end
    n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL clr_step: got %h want 0", kif.step); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL clr_after_step[%0d]: got %h want 0", i, kif.step); end
      n_cmp++; if (kif.held !== 8'h00) begin n_err++; $display("FAIL clr_after_held[%0d]: got %h want 00", i, kif.held); end
    end
  endtask

  task automatic test_reset_mid_hold();
    kif.keycode = 16'h0074;
    tick();
    n_cmp++; if (kif.step !== 4'h8) begin n_err++; $display("FAIL mid_first_step: got %h want 8", kif.step); end
    for (int c = 2; c <= 6; c++) tick();
    n_cmp++; if (kif.held !== 8'h08) begin n_err++; $display("FAIL mid_held: got %h want 08", kif.held); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (kif.held !== 8'h00) begin n_err++; $display("FAIL mid_async_held: got %h want 00", kif.held); end
    n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL mid_async_step: got %h want 0", kif.step); end
    n_cmp++; if (kif.released !== 8'h00) begin n_err++; $display("FAIL mid_async_rel: got %h want 00", kif.released); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (kif.step !== 4'h0) begin n_err++; $display("FAIL mid_after_step[%0d]: got %h want 0", i, kif.step); end
      n_cmp++; if (kif.held !== 8'h00) begin n_err++; $display("FAIL mid_after_held[%0d]: got %h want 00", i, kif.held); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_make_break();
    test_auto_repeat();
    test_ignored();
    test_clear_all();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
